// File: rtl/clk_div_prog.sv
// Programmable integer clock divider (N = 2..2^DIV_W-1) with glitch-free
// ratio and enable changes applied only on period boundaries.
module clk_div_prog #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             load,
  output logic             clk_out,
  output logic             clk_out_n,
  output logic             tick,
  output logic             ack,
  output logic             cfg_err
);

  // state | meaning
  // IDLE  | stopped, clk_out held low, counter parked at 0
  // RUN   | counting 0..N-1; high while cnt < ceil(N/2)
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] div, div_nx;
  logic [DIV_W-1:0] pend, pend_nx;
  logic             pend_vld, pend_vld_nx;
  logic             clk_nx, tick_nx, ack_nx, err_nx;

  logic [DIV_W-1:0] load_val;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W:0]   hi;
  logic             bad_val;
  logic             boundary;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      div       <= DIV_W'(DIV_RST);
      pend      <= '0;
      pend_vld  <= 1'b0;
      clk_out   <= 1'b0;
      clk_out_n <= 1'b1;
      tick      <= 1'b0;
      ack       <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      div       <= div_nx;
      pend      <= pend_nx;
      pend_vld  <= pend_vld_nx;
      clk_out   <= clk_nx;
      clk_out_n <= ~clk_nx;
      tick      <= tick_nx;
      ack       <= ack_nx;
      cfg_err   <= err_nx;
    end
  end

  // Divisors below 2 are clamped to 2 and flagged.
  assign bad_val  = (div_val < DIV_W'(2));
  assign load_val = bad_val ? DIV_W'(2) : div_val;
  assign cnt_inc  = cnt + DIV_W'(1);
  assign hi       = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
  assign boundary = (cnt == (div - DIV_W'(1)));

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    div_nx      = div;
    pend_nx     = pend;
    pend_vld_nx = pend_vld;
    clk_nx      = clk_out;
    tick_nx     = 1'b0;
    ack_nx      = 1'b0;
    err_nx      = load & bad_val;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        clk_nx = 1'b0;
        // No clock is running, so a new ratio can take effect at once.
        if (load) begin
          div_nx      = load_val;
          ack_nx      = 1'b1;
          pend_vld_nx = 1'b0;
        end else if (pend_vld) begin
          div_nx      = pend;
          ack_nx      = 1'b1;
          pend_vld_nx = 1'b0;
        end
        if (en) begin
          state_nx = RUN;
          clk_nx   = 1'b1;
          tick_nx  = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          if (pend_vld) begin
            div_nx      = pend;
            pend_vld_nx = 1'b0;
            ack_nx      = 1'b1;
          end
          cnt_nx = '0;
          if (en) begin
            clk_nx  = 1'b1;
            tick_nx = 1'b1;
          end else begin
            state_nx = IDLE;
            clk_nx   = 1'b0;
          end
        end else begin
          cnt_nx = cnt_inc;
          clk_nx = ({1'b0, cnt_inc} < hi);
        end
        // A load on the boundary cycle lands after the old value is applied.
        if (load) begin
          pend_nx     = load_val;
          pend_vld_nx = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by random
// traffic, compared each cycle against a period-position reference model.
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] div_val;
  logic       load;
  logic       clk_out, clk_out_n, tick, ack, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the current period and active ratio.
  bit m_run, m_pvld, m_clk, m_tick, m_ack, m_err;
  int m_pos, m_n, m_pend;

  int cyc = 0;
  int last_tick = -1;
  int last_gap = 0;
  int ack_cnt = 0;

  clk_div_prog #(.DIV_W(4), .DIV_RST(2)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .div_val   (div_val),
    .load      (load),
    .clk_out   (clk_out),
    .clk_out_n (clk_out_n),
    .tick      (tick),
    .ack       (ack),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit l, input int dv);
    bit prev;
    int lv;
    if (!r) begin
      m_run = 0; m_pos = 0; m_n = 2; m_pend = 0; m_pvld = 0;
      m_clk = 0; m_tick = 0; m_ack = 0; m_err = 0;
      return;
    end
    lv    = (dv < 2) ? 2 : dv;
    m_ack = 0;
    m_err = l && (dv < 2);
    if (!m_run) begin
      if (l) begin
        m_n = lv; m_ack = 1; m_pvld = 0;
      end else if (m_pvld) begin
        m_n = m_pend; m_ack = 1; m_pvld = 0;
      end
      m_pos = 0;
      m_run = e;
    end else begin
      if (m_pos == m_n - 1) begin
        if (m_pvld) begin
          m_n = m_pend; m_pvld = 0; m_ack = 1;
        end
        m_pos = 0;
        m_run = e;
      end else begin
        m_pos++;
      end
      if (l) begin
        m_pend = lv; m_pvld = 1;
      end
    end
    prev   = m_clk;
    m_clk  = m_run && (m_pos < (m_n + 1) / 2);
    m_tick = m_clk && !prev;
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int dv);
    reset   = r;
    en      = e;
    load    = l;
    div_val = 4'(dv);
    @(posedge clk_in);
    model_update(r, e, l, dv);
    @(negedge clk_in);
    check_val("clk_out", int'(clk_out), int'(m_clk));
    check_val("clk_out_n", int'(clk_out_n), int'(!m_clk));
    check_val("tick", int'(tick), int'(m_tick));
    check_val("ack", int'(ack), int'(m_ack));
    check_val("cfg_err", int'(cfg_err), int'(m_err));
    if (!r) last_tick = -1;
    if (tick === 1'b1) begin
      if (last_tick >= 0) last_gap = cyc - last_tick;
      last_tick = cyc;
    end
    if (ack === 1'b1) ack_cnt++;
    cyc++;
  endtask

  // Runs until the model sits at period position p (p < 0 selects N-1).
  task automatic wait_pos(input int p, input string tag);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_run && m_pos == ((p < 0) ? m_n - 1 : p)) begin
        found = 1;
        break;
      end
      step(1, 1, 0, 0);
    end
    check_val(tag, int'(found), 1);
  endtask

  initial begin
    reset = 0; en = 0; load = 0; div_val = '0;

    // Held in reset with en high: output stays parked.
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // Divide-by-2 out of reset.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    check_val("gap_n2", last_gap, 2);

    // Mid-period load of 5.
    wait_pos(0, "wait_n2_mid");
    step(1, 1, 1, 5);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
    check_val("gap_n5", last_gap, 5);

    // Switch to 7, then drop en at cnt=1 and re-raise it later.
    step(1, 1, 1, 7);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    check_val("gap_n7", last_gap, 7);
    wait_pos(1, "wait_n7_cnt1");
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    check_val("idle_low", int'(clk_out), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

    // Out-of-range load clamps to 2.
    step(1, 1, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    check_val("gap_clamp", last_gap, 2);

    // Back-to-back loads 6 then 3, first one on a boundary: one ack, N=3.
    wait_pos(-1, "wait_bnd");
    ack_cnt = 0;
    step(1, 1, 1, 6);
    step(1, 1, 1, 3);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    check_val("ack_once", ack_cnt, 1);
    check_val("gap_n3", last_gap, 3);

    // Reset during the high phase with a load pending.
    step(1, 1, 1, 9);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    wait_pos(1, "wait_n9_high");
    step(1, 1, 1, 4);
    step(0, 1, 0, 0);
    check_val("rst_low", int'(clk_out), 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    check_val("gap_rst", last_gap, 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
